// File: rtl/cmn_fifo_pkg.sv
// Shared defaults and pointer helpers for cmn_fifo.
package cmn_fifo_pkg;

  localparam int CMN_FIFO_DW_DEF = 32;
  localparam int CMN_FIFO_AW_DEF = 4;

  // Full means the low AW bits match and the wrap bits differ.
  function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                    input int aw);
    logic [31:0] m;
    m = (32'd1 << aw) - 32'd1;
    return ((wptr & m) == (rptr & m)) && (wptr[aw] != rptr[aw]);
  endfunction

endpackage

// File: rtl/cmn_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read. Not reset.
module cmn_fifo_mem #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cmn_fifo.sv
// Single-clock FWFT FIFO, depth 2**AW. Define CMN_FIFO_COUNT_EN to add the
// count output (registered-pointer difference).
module cmn_fifo
  import cmn_fifo_pkg::*;
#(
  parameter int DW = CMN_FIFO_DW_DEF,
  parameter int AW = CMN_FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
`ifdef CMN_FIFO_COUNT_EN
  ,
  output logic [AW:0]   count
`endif
);

  // Extra MSB distinguishes full from empty when the low bits match.
  logic [AW:0] wptr, rptr;
  logic        wr_acc, rd_acc;

  assign empty  = (wptr == rptr);
  assign full   = ptr_full(32'(wptr), 32'(rptr), AW);
  assign wr_acc = we & ~full;
  assign rd_acc = re & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + (AW+1)'(1);
      if (rd_acc) rptr <= rptr + (AW+1)'(1);
    end
  end

`ifdef CMN_FIFO_COUNT_EN
  assign count = wptr - rptr;
`endif

  cmn_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_cmn_fifo.sv
// Self-checking bench for cmn_fifo: small instance checked against a queue
// model, wide instance for the FWFT latency case.
module tb_cmn_fifo;

  localparam int SDW = 8;
  localparam int SAW = 2;
  localparam int SDEPTH = 1 << SAW;
  localparam int BDW = 46;
  localparam int BAW = 8;

  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic           s_we = 0, s_re = 0;
  logic [SDW-1:0] s_wdata = '0, s_rdata;
  logic           s_full, s_empty;
  logic           b_we = 0, b_re = 0;
  logic [BDW-1:0] b_wdata = '0, b_rdata;
  logic           b_full, b_empty;
`ifdef CMN_FIFO_COUNT_EN
  logic [SAW:0]   s_count;
  logic [BAW:0]   b_count;
`endif

  cmn_fifo #(.DW(SDW), .AW(SAW)) u_small (
    .clk(clk), .reset(reset), .we(s_we), .wdata(s_wdata), .re(s_re),
    .rdata(s_rdata), .full(s_full), .empty(s_empty)
`ifdef CMN_FIFO_COUNT_EN
    , .count(s_count)
`endif
  );

  cmn_fifo #(.DW(BDW), .AW(BAW)) u_big (
    .clk(clk), .reset(reset), .we(b_we), .wdata(b_wdata), .re(b_re),
    .rdata(b_rdata), .full(b_full), .empty(b_empty)
`ifdef CMN_FIFO_COUNT_EN
    , .count(b_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [SDW-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".empty"}, 64'(s_empty), 64'(q.size() == 0));
    chk({tag, ".full"},  64'(s_full),  64'(q.size() == SDEPTH));
    if (q.size() != 0) chk({tag, ".rdata"}, 64'(s_rdata), 64'(q[0]));
`ifdef CMN_FIFO_COUNT_EN
    chk({tag, ".count"}, 64'(s_count), 64'(q.size()));
`endif
  endtask

  // One clock on the small FIFO: drive at negedge, update model at the edge, check after.
  task automatic step(input logic w, input logic [SDW-1:0] d, input logic r, input string tag);
    bit acc_w, acc_r;
    @(negedge clk);
    s_we = w; s_wdata = d; s_re = r;
    acc_w = w && (q.size() < SDEPTH);
    acc_r = r && (q.size() > 0);
    @(posedge clk);
    if (acc_r) void'(q.pop_front());
    if (acc_w) q.push_back(d);
    #1;
    chk_state(tag);
  endtask

  initial begin
    // Reset, then idle reads on an empty FIFO.
    reset = 1;
    #12;
    chk("rst.empty", 64'(s_empty), 64'd1);
    chk("rst.full",  64'(s_full),  64'd0);
    chk("rst.b_empty", 64'(b_empty), 64'd1);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "idle_re");

    // Fill, drop on full, drain in order.
    step(1'b1, 8'h11, 1'b0, "fill");
    step(1'b1, 8'h22, 1'b0, "fill");
    step(1'b1, 8'h33, 1'b0, "fill");
    step(1'b1, 8'h44, 1'b0, "fill");
    chk("fill.full",  64'(s_full),  64'd1);
    chk("fill.head",  64'(s_rdata), 64'h11);
    step(1'b1, 8'h55, 1'b0, "drop");
    chk("drop.head",  64'(s_rdata), 64'h11);
    for (int i = 0; i < 4; i++) begin
      chk("drain.seq", 64'(s_rdata), 64'(8'h11 * (i + 1)));
      step(1'b0, '0, 1'b1, "drain");
    end
    chk("drain.empty", 64'(s_empty), 64'd1);

    // FWFT latency on the wide instance.
    @(negedge clk);
    b_we = 1; b_wdata = 46'h1234_DEADBEEF;
    @(posedge clk);
    #1;
    chk("fwft.empty", 64'(b_empty), 64'd0);
    chk("fwft.rdata", 64'(b_rdata), 64'h1234_DEADBEEF);
    @(negedge clk);
    b_we = 0;
    #1;
    chk("fwft.hold",  64'(b_rdata), 64'h1234_DEADBEEF);

    // Simultaneous push/pop at occupancy 2 across pointer wrap.
    step(1'b1, 8'hA0, 1'b0, "pre2");
    step(1'b1, 8'hA1, 1'b0, "pre2");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, "wr_rd");
      chk("wr_rd.occ", 64'(q.size()), 64'd2);
    end

    // Full with we&re: head pops, write dropped.
    step(1'b1, 8'($urandom), 1'b0, "top_up");
    step(1'b1, 8'($urandom), 1'b0, "top_up");
    chk("fullrw.pre", 64'(s_full), 64'd1);
    step(1'b1, 8'hEE, 1'b1, "fullrw");
    chk("fullrw.notfull", 64'(s_full), 64'd0);
    while (q.size() != 0) begin
      chk("fullrw.no_ee", 64'(s_rdata == 8'hEE), 64'd0);
      step(1'b0, '0, 1'b1, "fullrw_drain");
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");

    // Asynchronous reset with 3 entries stored.
    while (q.size() > 3) step(1'b0, '0, 1'b1, "to3");
    while (q.size() < 3) step(1'b1, 8'($urandom), 1'b0, "to3");
    @(negedge clk);
    s_we = 0; s_re = 0;
    #2;
    reset = 1;
    #1;
    q.delete();
    chk("arst.empty", 64'(s_empty), 64'd1);
    chk("arst.full",  64'(s_full),  64'd0);
    chk("arst.b_empty", 64'(b_empty), 64'd1);
`ifdef CMN_FIFO_COUNT_EN
    chk("arst.count", 64'(s_count), 64'd0);
`endif
    @(negedge clk);
    reset = 0;
    step(1'b1, 8'h5A, 1'b0, "post_rst");
    step(1'b0, '0, 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
